// File: rtl/mac_pkt_fifo_if.sv
// Packet stream bundle between the MAC receive path and the user side.
// The FIFO takes the slave view; the source/sink takes the master view.
interface mac_pkt_fifo_if #(
  parameter int DATA_W = 64,
  parameter int MOD_W  = $clog2(DATA_W/8)
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [MOD_W-1:0]  in_mod;
  logic              in_err;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [MOD_W-1:0]  out_mod;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_mod, in_err, out_ready,
    input  out_valid, out_data, out_sop, out_eop, out_mod
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_mod, in_err, out_ready,
    output out_valid, out_data, out_sop, out_eop, out_mod
  );
endinterface

// File: rtl/mac_pkt_fifo.sv
// Store-and-forward packet FIFO: frames become readable only after a clean EOP;
// errored, runt, overflowing or protocol-broken frames are rolled back whole.
module mac_pkt_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 512,
  parameter int MOD_W     = $clog2(DATA_W/8),
  parameter int CNT_W     = 32,
  parameter int MIN_BEATS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_pkt_fifo_if.slave          io_pkt,
  output logic [$clog2(DEPTH):0] frames_avail,
  output logic [CNT_W-1:0]       ok_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_W + MOD_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} wstate_t;

  wstate_t           r_state, w_state_nxt;
  logic [PW-1:0]     r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [WW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_frames_avail;
  logic [CNT_W-1:0]  r_ok_cnt, r_drop_cnt;

  logic              r_out_valid, r_out_sop, r_out_eop;
  logic [MOD_W-1:0]  r_out_mod;
  logic [DATA_W-1:0] r_out_data;

  logic              w_beat, w_ovf, w_bad;
  logic [PW-1:0]     w_wa, w_len;
  logic              w_we, w_commit, w_drop_new, w_abort;
  logic [1:0]        w_drop_inc;
  logic              w_xfer, w_eop_xfer, w_ld_ok;
  logic [PW-1:0]     w_ld_ptr;
  logic [WW-1:0]     w_rd_word;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // A beat belongs to a frame if we are mid-frame or it opens one; a sop
  // always (re)starts from the committed pointer, discarding any partial frame.
  assign w_beat = io_pkt.in_valid && (r_state == S_WRITE || io_pkt.in_sop);
  assign w_wa   = (r_state == S_WRITE && !io_pkt.in_sop) ? r_wr_ptr : r_wr_commit;
  assign w_ovf  = w_beat && ((w_wa - r_rd_ptr) == PW'(DEPTH));
  assign w_len  = w_wa - r_wr_commit + PW'(1);
  assign w_bad  = io_pkt.in_err || (w_len < PW'(MIN_BEATS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) begin
      if (io_pkt.in_eop) w_state_nxt = S_IDLE;
      else if (w_ovf)    w_state_nxt = S_DISCARD;
      else               w_state_nxt = S_WRITE;
    end else if (r_state == S_DISCARD && io_pkt.in_valid && io_pkt.in_eop) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_we       = 1'b0;
    w_commit   = 1'b0;
    w_drop_new = 1'b0;
    w_abort    = 1'b0;
    if (w_beat) begin
      w_abort = (r_state == S_WRITE) && io_pkt.in_sop;
      if (w_ovf) begin
        w_drop_new = 1'b1;
      end else begin
        w_we = 1'b1;
        if (io_pkt.in_eop) begin
          if (w_bad) w_drop_new = 1'b1;
          else       w_commit   = 1'b1;
        end
      end
    end
  end

  assign w_drop_inc = {1'b0, w_abort} + {1'b0, w_drop_new};

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_wa[AW-1:0]] <= {io_pkt.in_sop, io_pkt.in_eop, io_pkt.in_mod, io_pkt.in_data};
  end

  // Output register holds the head entry; r_rd_ptr only moves on a transfer,
  // so the displayed beat still occupies its slot for the full check.
  assign w_xfer     = r_out_valid && io_pkt.out_ready;
  assign w_eop_xfer = w_xfer && r_out_eop;
  assign w_ld_ptr   = r_out_valid ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign w_ld_ok    = (w_ld_ptr != r_wr_commit);
  assign w_rd_word  = r_mem[w_ld_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_wr_commit    <= '0;
      r_rd_ptr       <= '0;
      r_frames_avail <= '0;
      r_ok_cnt       <= '0;
      r_drop_cnt     <= '0;
      r_out_valid    <= 1'b0;
      r_out_sop      <= 1'b0;
      r_out_eop      <= 1'b0;
      r_out_mod      <= '0;
      r_out_data     <= '0;
    end else begin
      if (w_drop_new)  r_wr_ptr <= r_wr_commit;
      else if (w_we)   r_wr_ptr <= w_wa + PW'(1);
      if (w_commit)    r_wr_commit <= w_wa + PW'(1);

      case ({w_commit, w_eop_xfer})
        2'b10:   r_frames_avail <= r_frames_avail + PW'(1);
        2'b01:   r_frames_avail <= r_frames_avail - PW'(1);
        default: r_frames_avail <= r_frames_avail;
      endcase

      r_ok_cnt   <= sat_add(r_ok_cnt, {1'b0, w_commit});
      r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);

      if (w_xfer) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (!r_out_valid || w_xfer) begin
        r_out_valid <= w_ld_ok;
        if (w_ld_ok) {r_out_sop, r_out_eop, r_out_mod, r_out_data} <= w_rd_word;
      end
    end
  end

  assign io_pkt.out_valid = r_out_valid;
  assign io_pkt.out_sop   = r_out_sop;
  assign io_pkt.out_eop   = r_out_eop;
  assign io_pkt.out_mod   = r_out_mod;
  assign io_pkt.out_data  = r_out_data;
  assign frames_avail     = r_frames_avail;
  assign ok_cnt           = r_ok_cnt;
  assign drop_cnt         = r_drop_cnt;
endmodule

// File: tb/tb_mac_pkt_fifo.sv
// Randomised scoreboard bench for mac_pkt_fifo: a frame-level model decides
// which frames survive and queues their beats; a monitor checks the output.
module tb_mac_pkt_fifo;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 16;
  localparam int MOD_W     = 3;
  localparam int CNT_W     = 4;
  localparam int MIN_BEATS = 2;
  localparam int PW        = $clog2(DEPTH) + 1;
  localparam int CMAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PW-1:0]    frames_avail;
  logic [CNT_W-1:0] ok_cnt, drop_cnt;

  mac_pkt_fifo_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  mac_pkt_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MOD_W(MOD_W), .CNT_W(CNT_W), .MIN_BEATS(MIN_BEATS)
  ) dut (
    .clk(clk), .reset(reset), .io_pkt(bus),
    .frames_avail(frames_avail), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int committed = 0, popped = 0;
  int exp_ok = 0, exp_drop = 0;
  bit abort_pend = 0;
  int rdy_mode = 3;
  bit chk_fa = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reader: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled.
  int ph = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       begin bus.out_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, hold-while-stalled, frames_avail decrement.
  beat_t held, cur, e;
  bit stall = 0, fa_pend = 0;
  logic [PW-1:0] fa_prev;
  always @(negedge clk) begin
    cur = '{sop: bus.out_sop, eop: bus.out_eop, mod: bus.out_mod, data: bus.out_data};
    if (reset) begin
      stall = 0;
      fa_pend = 0;
    end else begin
      if (fa_pend) begin
        fa_pend = 0;
        if (chk_fa) check("fa_dec", frames_avail, fa_prev - PW'(1));
      end
      if (stall) check("stall_hold", {bus.out_valid, cur}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", cur.data, e.data);
          check("beat_flags", {cur.sop, cur.eop}, {e.sop, e.eop});
          if (e.eop) check("beat_mod", cur.mod, e.mod);
        end
        popped++;
        if (bus.out_eop) begin fa_pend = 1; fa_prev = frames_avail; end
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = cur;
    end
  end

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_err = 0; bus.in_mod = '0;
    end
  endtask

  // Frame-level model: survives iff clean EOP, no error, long enough, and it
  // fits in the space left by committed-but-unread beats.
  task automatic send_frame(input int len, input bit err, input int mod, input bit no_eop, input bit wait_space);
    beat_t fb[$];
    beat_t b;
    int t, occ;
    bit good, last;
    if (wait_space) begin
      t = 0;
      while (committed - popped + len > DEPTH && t < 3000) begin drive_idle(1); t++; end
      if (t >= 3000) begin
        n_cmp++; n_err++;
        $display("FAIL space_timeout: got occupancy %0d, expected room for %0d", committed - popped, len);
      end
    end
    if (abort_pend) begin exp_drop++; abort_pend = 0; end
    occ  = committed - popped;
    good = !err && !no_eop && len >= MIN_BEATS && occ + len <= DEPTH;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1) && !no_eop;
      b.sop  = (i == 0);
      b.eop  = last;
      b.mod  = last ? MOD_W'(mod) : '0;
      b.data = {$urandom, $urandom};
      fb.push_back(b);
      @(posedge clk); #1;
      bus.in_valid = 1; bus.in_sop = b.sop; bus.in_eop = b.eop; bus.in_mod = b.mod;
      bus.in_data = b.data;
      bus.in_err = last ? err : 1'($urandom_range(0, 1));
      if (last && good) begin
        foreach (fb[k]) exp_q.push_back(fb[k]);
        committed += len;
      end
    end
    if (no_eop)    abort_pend = 1;
    else if (good) exp_ok++;
    else           exp_drop++;
  endtask

  task automatic stray_beat();
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_sop = 0; bus.in_eop = 1'($urandom_range(0, 1));
    bus.in_err = 0; bus.in_mod = '0; bus.in_data = {$urandom, $urandom};
  endtask

  task automatic drain(input string name);
    int t = 0;
    drive_idle(2);
    while ((exp_q.size() != 0 || bus.out_valid) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      n_cmp++; n_err++;
      $display("FAIL %s_drain: got %0d beats pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_counts(input string name, input int fa);
    @(negedge clk);
    check({name, "_ok"}, ok_cnt, sat(exp_ok));
    check({name, "_drop"}, drop_cnt, sat(exp_drop));
    check({name, "_fa"}, frames_avail, fa);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_err = 0; bus.in_mod = '0;
    exp_q.delete();
    committed = 0; popped = 0; exp_ok = 0; exp_drop = 0; abort_pend = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_err = 0;
    bus.in_mod = '0; bus.in_data = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_mod, bus.out_data}, '0);
    check_counts("rst", 0);
    #1 reset = 0;
    rdy_mode = 0;

    // Partial frame lost by reset, not counted.
    send_frame(3, 0, 0, 1, 0);
    do_reset();
    drive_idle(4);
    check("midrst_valid", bus.out_valid, 0);
    check_counts("midrst", 0);

    // Single clean 8-beat frame.
    send_frame(8, 0, 3, 0, 1);
    drain("clean");
    check_counts("clean", 0);

    // Errored frame, then good frame; runt and minimum-length boundary.
    send_frame(5, 1, 2, 0, 1);
    send_frame(4, 0, 5, 0, 1);
    send_frame(1, 0, 1, 0, 1);
    send_frame(2, 0, 0, 0, 1);
    drain("err");
    check_counts("err", 0);

    // Overflow with the reader stalled.
    rdy_mode = 3;
    drive_idle(3);
    send_frame(10, 0, 4, 0, 0);
    drive_idle(2);
    @(negedge clk);
    check("fwft_latency", {bus.out_valid, bus.out_sop}, 2'b11);
    send_frame(10, 0, 6, 0, 0);
    drive_idle(3);
    check_counts("ovf", 1);
    rdy_mode = 0;
    drain("ovf");
    check_counts("ovf_done", 0);

    // Backpressure 1,0,0,1 over three 6-beat frames.
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) send_frame(6, 0, i + 1, 0, 1);
    drive_idle(2);
    chk_fa = 1;
    drain("bp");
    chk_fa = 0;
    check_counts("bp", 0);

    // Mid-frame sop aborts; stray non-sop beat in IDLE is ignored.
    rdy_mode = 0;
    send_frame(3, 0, 0, 1, 1);
    send_frame(5, 0, 7, 0, 1);
    stray_beat();
    drain("proto");
    check_counts("proto", 0);

    // Random mix, random reader.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      send_frame($urandom_range(1, 8), ($urandom_range(0, 9) == 0), $urandom_range(0, 7), 0, 1);
      drive_idle($urandom_range(0, 2));
    end
    drain("mix");
    check_counts("mix", 0);

    // 100 frames of 13 beats through a 16-deep buffer; ok_cnt saturates.
    for (int i = 0; i < 100; i++) send_frame(13, 0, $urandom_range(0, 7), 0, 1);
    drain("wrap");
    check_counts("wrap", 0);

    // drop_cnt saturation from a clean start.
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) send_frame($urandom_range(2, 5), 1, 0, 0, 1);
    drain("sat");
    check_counts("sat", 0);
    check("sat_drop_max", drop_cnt, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mac_pkt_fifo.md
Name: mac_pkt_fifo

Overview:
Parametrised store-and-forward packet FIFO between the 10G MAC receive path and the user side. Frames are written beat by beat and become visible to the reader only after a clean EOP. Frames with an error, overflow or protocol violation are discarded whole. Saturating counters report accepted and dropped frames to the verification environment and the status registers.

Parameters:
DATA_W, 64, data beat width in bits; multiple of 8, 32..512
DEPTH, 512, FIFO entries in beats; power of two, >=16
MOD_W, $clog2(DATA_W/8), width of the valid-byte modulo field
CNT_W, 32, width of the statistics counters
MIN_BEATS, 1, frames shorter than this many beats are dropped as runts

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  write beat present; no backpressure, the source never stalls
in_data  in  DATA_W  write beat payload
in_sop  in  1  first beat of frame
in_eop  in  1  last beat of frame
in_mod  in  MOD_W  valid bytes on EOP beat; 0 = all bytes valid
in_err  in  1  frame error; sampled on EOP beat only
out_valid  out  1  read beat valid
out_ready  in  1  reader accepts beat
out_data  out  DATA_W  read beat payload
out_sop  out  1  first beat of frame
out_eop  out  1  last beat of frame
out_mod  out  MOD_W  valid bytes on EOP beat
frames_avail  out  $clog2(DEPTH)+1  committed frames not yet fully read
ok_cnt  out  CNT_W  frames committed, saturating
drop_cnt  out  CNT_W  frames dropped, saturating

Behaviour:
- Reset (async assert, sync release): all pointers 0; write FSM IDLE; out_valid, out_sop, out_eop, out_data, out_mod = 0; frames_avail, ok_cnt, drop_cnt = 0.
- Storage: RAM word = {sop, eop, mod, data}. Pointers are $clog2(DEPTH)+1 bits. wr_ptr is speculative, wr_commit is committed, rd_ptr is the read pointer. full = (wr_ptr - rd_ptr) == DEPTH.
- Write FSM states: IDLE, WRITE, DISCARD.
  - IDLE: an in_valid beat without in_sop is ignored, with no count. A valid beat with sop is written and the FSM goes to WRITE. If the same beat also has eop, the EOP rules below apply in the same cycle.
  - WRITE: each valid beat is written and wr_ptr increments.
  - WRITE, sop again before eop: the current frame is dropped (drop_cnt+1, wr_ptr <= wr_commit). The new frame restarts from wr_commit.
  - WRITE, beat arrives while full: the frame is dropped (drop_cnt+1, wr_ptr <= wr_commit) and the FSM goes to DISCARD.
  - EOP beat: the frame is dropped if in_err=1 or its length in beats < MIN_BEATS. Otherwise wr_commit <= wr_ptr+1, frames_avail+1, ok_cnt+1. The FSM returns to IDLE.
  - DISCARD: beats are swallowed until an eop beat, then the FSM returns to IDLE. A sop in DISCARD starts a new frame as in IDLE.
- Read side: first-word-fall-through with a registered output stage.
  - The reader may fetch only entries below wr_commit, never speculative data.
  - out_valid rises at most 2 cycles after frames_avail becomes nonzero.
  - A beat transfers when out_valid && out_ready. The next beat is presented in the following cycle, so sustained throughput is 1 beat/clk.
  - With out_valid=1 and out_ready=0, all out_* fields hold stable.
  - A transferred beat with out_eop decrements frames_avail.
  - A commit and an EOP read in the same cycle leave frames_avail unchanged.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Pointers wrap modulo 2*DEPTH. Wrap is transparent to frame contents.
- Reset mid-frame: the partial frame is lost and is not counted in drop_cnt.

Test Plan:
- Single clean frame: 8 beats, sop at beat 0, eop at beat 7, mod=3, err=0. out_ready=1 -> 8 identical beats out in order, last out_mod=3; ok_cnt=1, frames_avail returns to 0.
- Error frame then good frame: 5-beat frame with err=1, then a 4-beat good frame -> only the 4-beat frame appears at the output; drop_cnt=1, ok_cnt=1, no error-frame beats ever visible.
- Overflow: DEPTH=16, out_ready=0, write a 10-beat frame then a 10-beat frame -> second frame dropped at beat 7; drop_cnt=1; FSM in DISCARD until its eop. Release out_ready -> exactly the first frame is read.
- Backpressure: 3 frames of 6 beats, out_ready toggling 1,0,0,1 -> out_* stable while stalled; all 18 beats delivered in order; frames_avail decrements on each eop transfer.
- Protocol: mid-frame sop after 3 beats -> first frame dropped, second delivered; stray non-sop beat in IDLE -> ignored, no count change.
- Wrap and saturation: 100 frames of 13 beats through DEPTH=16 -> data intact across wraps. With CNT_W=4, 20 errored frames -> drop_cnt=15.
